// File: rtl/dmem_bridge.sv
// MEM-stage data-memory bridge: in-order store buffer with load forwarding,
// blocking load-miss FSM and a valid/ready request / valid response memory port.
module dmem_bridge #(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        proc2Dmem_command,
  input  logic [ADDR_W-1:0] proc2Dmem_addr,
  input  logic [31:0]       proc2mem_data,
  output logic [31:0]       mem2proc_data,
  output logic              dmem_stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_W - 2;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2,
    BUS_RSVD  = 2'd3
  } bus_cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_REQ  = 2'd1,
    LD_RSP  = 2'd2,
    LD_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              drain_pend_q, drain_pend_d;
  logic [WA_W-1:0]   ld_addr_q, ld_addr_d;
  logic [31:0]       result_q, result_d;
  logic [WA_W-1:0]   sb_addr_q [SB_DEPTH];
  logic [31:0]       sb_data_q [SB_DEPTH];

  logic [WA_W-1:0]   word_addr;
  logic              is_load, is_store, full;
  logic              fwd_hit;
  logic [31:0]       fwd_data;
  logic              ld_miss, drain;
  logic              push, pop;
  logic              stall;
  logic              req_valid, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata, rdata;
  logic              addr_lsb_unused;

  always_comb begin
    word_addr       = proc2Dmem_addr[ADDR_W-1:2];
    addr_lsb_unused = ^proc2Dmem_addr[1:0];
    is_load         = (proc2Dmem_command == BUS_LOAD);
    is_store        = (proc2Dmem_command == BUS_STORE);
    full            = (count_q == CNT_W'(SB_DEPTH));
  end

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned k = 0; k < SB_DEPTH; k++) begin
      if ((CNT_W'(k) < count_q) &&
          (sb_addr_q[head_q + PTR_W'(k)] == word_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data_q[head_q + PTR_W'(k)];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ld_addr_d    = ld_addr_q;
    result_d     = result_q;
    drain_pend_d = 1'b0;
    ld_miss      = 1'b0;
    drain        = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    stall        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    rdata        = '0;

    unique case (state_q)
      IDLE: begin
        ld_miss = is_load && !fwd_hit;
        if (is_load && fwd_hit) rdata = fwd_data;
        if (is_store) begin
          if (full) stall = 1'b1;
          else      push  = 1'b1;
        end
        if (ld_miss) stall = 1'b1;
        // A presented write is never withdrawn; a new miss only blocks fresh drains.
        drain = drain_pend_q || ((count_q != '0) && !ld_miss);
        if (drain) begin
          req_valid    = 1'b1;
          req_we       = 1'b1;
          req_addr     = {sb_addr_q[head_q], 2'b00};
          req_wdata    = sb_data_q[head_q];
          pop          = mem_req_ready;
          drain_pend_d = !mem_req_ready;
        end
        if (ld_miss && (!drain_pend_q || mem_req_ready)) begin
          state_d   = LD_REQ;
          ld_addr_d = word_addr;
        end
      end
      LD_REQ: begin
        stall     = 1'b1;
        req_valid = 1'b1;
        req_addr  = {ld_addr_q, 2'b00};
        if (mem_req_ready) state_d = LD_RSP;
      end
      LD_RSP: begin
        stall = 1'b1;
        if (mem_rsp_valid) begin
          result_d = mem_rsp_data;
          state_d  = LD_DONE;
        end
      end
      LD_DONE: begin
        rdata   = result_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Outputs are forced low while reset is held, even if the pipeline still
  // presents a LOAD that would otherwise raise a combinational stall.
  always_comb begin
    dmem_stall    = rst ? stall     : 1'b0;
    mem2proc_data = rst ? rdata     : '0;
    mem_req_valid = rst ? req_valid : 1'b0;
    mem_req_we    = rst ? req_we    : 1'b0;
    mem_req_addr  = rst ? req_addr  : '0;
    mem_req_wdata = rst ? req_wdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      drain_pend_q <= 1'b0;
      ld_addr_q    <= '0;
      result_q     <= '0;
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
        sb_addr_q[i] <= '0;
        sb_data_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      drain_pend_q <= drain_pend_d;
      ld_addr_q    <= ld_addr_d;
      result_q     <= result_d;
      if (push) begin
        sb_addr_q[tail_q] <= word_addr;
        sb_data_q[tail_q] <= proc2mem_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: memory requests and load results are checked
// against expectation queues filled as the stimulus is driven.
module tb_dmem_bridge;

  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] LD   = 2'd1;
  localparam logic [1:0] ST   = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cmd;
  logic [31:0] addr, wdata;
  logic [31:0] mem2proc_data;
  logic        dmem_stall;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  req_t        exp_q [$];
  logic [31:0] ld_q  [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_bridge #(.SB_DEPTH(4), .ADDR_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .proc2Dmem_command (cmd),
    .proc2Dmem_addr    (addr),
    .proc2mem_data     (wdata),
    .mem2proc_data     (mem2proc_data),
    .dmem_stall        (dmem_stall),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_we        (mem_req_we),
    .mem_req_addr      (mem_req_addr),
    .mem_req_wdata     (mem_req_wdata),
    .mem_rsp_valid     (mem_rsp_valid),
    .mem_rsp_data      (mem_rsp_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic we, input logic [31:0] a, input logic [31:0] d);
    req_t e;
    e.we   = we;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // One cycle: inputs change on the falling edge, outputs are checked 2ns later.
  task automatic cyc(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d,
                     input logic rdy, input logic rv, input logic [31:0] rd);
    @(negedge clk);
    cmd           = c;
    addr          = a;
    wdata         = d;
    mem_req_ready = rdy;
    mem_rsp_valid = rv;
    mem_rsp_data  = rd;
    #2;
  endtask

  task automatic drain_all(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(NONE, 0, 0, 1'b1, 1'b0, 0);
    cyc(NONE, 0, 0, 1'b0, 1'b0, 0);
    chk({tag, "_queue_left"}, 32'(exp_q.size()), 0);
    chk({tag, "_idle_valid"}, 32'(mem_req_valid), 0);
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [31:0] rsp,
                         input int exp_stalls);
    int stalls = 0;
    int acc    = -1;
    int k      = 0;
    bit done   = 1'b0;
    push_req(1'b0, {a[31:2], 2'b00}, 0);
    ld_q.push_back(rsp);
    while (!done && k < 40) begin
      cyc(LD, a, 0, 1'b1, (acc >= 0 && k == acc + 3), rsp);
      if (mem_req_valid && !mem_req_we) acc = k;
      if (dmem_stall) stalls++;
      else begin
        done = 1'b1;
        chk({tag, "_data"}, mem2proc_data, ld_q.pop_front());
      end
      k++;
    end
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
  endtask

  // Request monitor: compares every accepted request against the scoreboard.
  always begin : mon
    req_t e;
    @(negedge clk);
    #4;
    if (mem_req_valid && mem_req_ready) begin
      chk("req_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("req_we", 32'(mem_req_we), 32'(e.we));
        chk("req_addr", mem_req_addr, e.addr);
        if (e.we) chk("req_wdata", mem_req_wdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cmd = NONE; addr = 0; wdata = 0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 0;
    #2;
    chk("rst_stall", 32'(dmem_stall), 0);
    chk("rst_valid", 32'(mem_req_valid), 0);
    chk("rst_we", 32'(mem_req_we), 0);
    chk("rst_addr", mem_req_addr, 0);
    chk("rst_wdata", mem_req_wdata, 0);
    chk("rst_rdata", mem2proc_data, 0);
    @(negedge clk);
    rst = 1'b1;

    // Reset in the middle of a miss with two stores buffered
    cyc(ST, 'h10, 'h11, 1'b0, 1'b0, 0);
    chk("A_st0_stall", 32'(dmem_stall), 0);
    cyc(ST, 'h14, 'h22, 1'b0, 1'b0, 0);
    chk("A_st1_stall", 32'(dmem_stall), 0);
    chk("A_drain_up", 32'(mem_req_valid), 1);
    push_req(1'b1, 'h10, 'h11);
    cyc(ST, 'h18, 'h33, 1'b1, 1'b0, 0);
    chk("A_st2_stall", 32'(dmem_stall), 0);
    push_req(1'b0, 'h300, 0);
    cyc(LD, 'h300, 0, 1'b0, 1'b0, 0);
    chk("A_miss_stall", 32'(dmem_stall), 1);
    chk("A_miss_nodrain", 32'(mem_req_valid), 0);
    cyc(LD, 'h300, 0, 1'b1, 1'b0, 0);
    chk("A_ldreq_valid", 32'(mem_req_valid), 1);
    chk("A_ldreq_we", 32'(mem_req_we), 0);
    cyc(LD, 'h300, 0, 1'b0, 1'b0, 0);
    chk("A_ldrsp_stall", 32'(dmem_stall), 1);
    #1 rst = 1'b0;
    #1;
    chk("A_rst_stall", 32'(dmem_stall), 0);
    chk("A_rst_valid", 32'(mem_req_valid), 0);
    chk("A_rst_we", 32'(mem_req_we), 0);
    chk("A_rst_addr", mem_req_addr, 0);
    chk("A_rst_wdata", mem_req_wdata, 0);
    chk("A_rst_rdata", mem2proc_data, 0);
    @(negedge clk);
    rst = 1'b1; cmd = NONE; mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_data = 'hBAD0BAD0;
    #2;
    chk("A_post_stall", 32'(dmem_stall), 0);
    chk("A_post_valid", 32'(mem_req_valid), 0);
    cyc(NONE, 0, 0, 1'b1, 1'b0, 0);
    chk("A_empty_valid0", 32'(mem_req_valid), 0);
    chk("A_empty_stall", 32'(dmem_stall), 0);
    cyc(NONE, 0, 0, 1'b1, 1'b0, 0);
    chk("A_empty_valid1", 32'(mem_req_valid), 0);
    chk("A_queue_left", 32'(exp_q.size()), 0);

    // Full buffer: fifth store stalls until a slot frees
    for (int i = 0; i < 4; i++) begin
      push_req(1'b1, 32'('h10 + 4 * i), 32'('hB0 + i));
      cyc(ST, 32'('h10 + 4 * i), 32'('hB0 + i), 1'b0, 1'b0, 0);
      chk("B_fill_stall", 32'(dmem_stall), 0);
    end
    push_req(1'b1, 'h20, 'hB4);
    cyc(ST, 'h20, 'hB4, 1'b0, 1'b0, 0);
    chk("B_full_stall", 32'(dmem_stall), 1);
    cyc(ST, 'h20, 'hB4, 1'b0, 1'b0, 0);
    chk("B_full_stall2", 32'(dmem_stall), 1);
    chk("B_hold_addr", mem_req_addr, 'h10);
    chk("B_hold_wdata", mem_req_wdata, 'hB0);
    cyc(ST, 'h20, 'hB4, 1'b1, 1'b0, 0);
    chk("B_pop_stall", 32'(dmem_stall), 1);
    cyc(ST, 'h20, 'hB4, 1'b0, 1'b0, 0);
    chk("B_enq_stall", 32'(dmem_stall), 0);
    drain_all("B");

    // Forwarding from the youngest matching entry
    cyc(ST, 'h43, 'hAAAA, 1'b0, 1'b0, 0);
    chk("C_st0_stall", 32'(dmem_stall), 0);
    cyc(ST, 'h40, 'hBBBB, 1'b0, 1'b0, 0);
    chk("C_st1_stall", 32'(dmem_stall), 0);
    cyc(LD, 'h42, 0, 1'b0, 1'b0, 0);
    chk("C_fwd_stall", 32'(dmem_stall), 0);
    chk("C_fwd_data", mem2proc_data, 'hBBBB);
    chk("C_no_read", 32'(mem_req_we), 1);
    chk("C_drain_addr", mem_req_addr, 'h40);
    chk("C_drain_wdata", mem_req_wdata, 'hAAAA);
    push_req(1'b1, 'h40, 'hAAAA);
    push_req(1'b1, 'h40, 'hBBBB);
    drain_all("C");

    // Plain miss with a 3-cycle response
    do_load("D", 'h100, 'hDEADBEEF, 5);

    // Miss arriving while a drain is in flight
    cyc(ST, 'h10, 'hE0, 1'b0, 1'b0, 0);
    cyc(ST, 'h14, 'hE1, 1'b0, 1'b0, 0);
    cyc(ST, 'h18, 'hE2, 1'b0, 1'b0, 0);
    push_req(1'b1, 'h10, 'hE0);
    push_req(1'b0, 'h200, 0);
    push_req(1'b1, 'h14, 'hE1);
    push_req(1'b1, 'h18, 'hE2);
    for (int i = 0; i < 2; i++) begin
      cyc(LD, 'h200, 0, 1'b0, 1'b0, 0);
      chk("E_wait_stall", 32'(dmem_stall), 1);
      chk("E_hold_valid", 32'(mem_req_valid), 1);
      chk("E_hold_we", 32'(mem_req_we), 1);
      chk("E_hold_addr", mem_req_addr, 'h10);
      chk("E_hold_wdata", mem_req_wdata, 'hE0);
    end
    cyc(LD, 'h200, 0, 1'b1, 1'b0, 0);
    chk("E_pop_stall", 32'(dmem_stall), 1);
    chk("E_pop_addr", mem_req_addr, 'h10);
    cyc(LD, 'h200, 0, 1'b1, 1'b0, 0);
    chk("E_rd_valid", 32'(mem_req_valid), 1);
    chk("E_rd_we", 32'(mem_req_we), 0);
    chk("E_rd_addr", mem_req_addr, 'h200);
    cyc(LD, 'h200, 0, 1'b1, 1'b0, 0);
    chk("E_rsp_nodrain", 32'(mem_req_valid), 0);
    chk("E_rsp_stall", 32'(dmem_stall), 1);
    cyc(LD, 'h200, 0, 1'b1, 1'b1, 'h12345678);
    chk("E_rsp2_nodrain", 32'(mem_req_valid), 0);
    cyc(LD, 'h200, 0, 1'b1, 1'b0, 0);
    chk("E_done_stall", 32'(dmem_stall), 0);
    chk("E_done_data", mem2proc_data, 'h12345678);
    chk("E_done_nodrain", 32'(mem_req_valid), 0);
    drain_all("E");

    // Enqueue and pop together at count 2, tail wrapping 3 -> 0
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    push_req(1'b1, 'h500, 'hF0);
    push_req(1'b1, 'h504, 'hF1);
    cyc(ST, 'h500, 'hF0, 1'b0, 1'b0, 0);
    cyc(ST, 'h504, 'hF1, 1'b0, 1'b0, 0);
    cyc(ST, 'h508, 'hF2, 1'b1, 1'b0, 0);
    chk("F_enqpop0_stall", 32'(dmem_stall), 0);
    cyc(ST, 'h50C, 'hF3, 1'b1, 1'b0, 0);
    chk("F_enqpop1_stall", 32'(dmem_stall), 0);
    cyc(LD, 'h50C, 0, 1'b0, 1'b0, 0);
    chk("F_fwd50C", mem2proc_data, 'hF3);
    cyc(LD, 'h508, 0, 1'b0, 1'b0, 0);
    chk("F_fwd508", mem2proc_data, 'hF2);
    cyc(ST, 'h510, 'hF4, 1'b0, 1'b0, 0);
    chk("F_st3_stall", 32'(dmem_stall), 0);
    cyc(ST, 'h514, 'hF5, 1'b0, 1'b0, 0);
    chk("F_st4_stall", 32'(dmem_stall), 0);
    cyc(ST, 'h518, 'hF6, 1'b0, 1'b0, 0);
    chk("F_full_stall", 32'(dmem_stall), 1);
    cyc(LD, 'h510, 0, 1'b0, 1'b0, 0);
    chk("F_fwd510", mem2proc_data, 'hF4);
    chk("F_fwd510_stall", 32'(dmem_stall), 0);
    cyc(LD, 'h514, 0, 1'b0, 1'b0, 0);
    chk("F_fwd514", mem2proc_data, 'hF5);
    push_req(1'b1, 'h508, 'hF2);
    push_req(1'b1, 'h50C, 'hF3);
    push_req(1'b1, 'h510, 'hF4);
    push_req(1'b1, 'h514, 'hF5);
    drain_all("F");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Data-memory interface between the 5-stage pipeline's MEM-stage data port and a variable-latency memory using a valid/ready request channel and a valid response channel.
- Buffers stores in a small in-order store buffer so they retire without stalling.
- Forwards buffered store data to matching loads.
- Holds loads with a stall signal until the memory responds.

Parameters:
- SB_DEPTH, 4, store-buffer entries (power of two, ≥2).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low; all state cleared while low.
- proc2Dmem_command  in  2  0=BUS_NONE, 1=BUS_LOAD, 2=BUS_STORE; 3 treated as NONE.
- proc2Dmem_addr  in  ADDR_W  byte address; bits [1:0] ignored (word access only).
- proc2mem_data  in  32  store data.
- mem2proc_data  out  32  load result; valid in any cycle with LOAD command and dmem_stall=0.
- dmem_stall  out  1  pipeline must freeze and hold the command/addr/data stable.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_we  out  1  1=write, 0=read.
- mem_req_addr  out  ADDR_W  word-aligned address ([1:0]=0).
- mem_req_wdata  out  32  write data.
- mem_rsp_valid  in  1  read data valid; one pulse per accepted read.
- mem_rsp_data  in  32  read data.

Behaviour:
- Reset (rst=0):
  - FSM=IDLE, buffer empty (head=tail=count=0).
  - dmem_stall=0, mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0, mem2proc_data=0.
  - Reset mid-operation discards buffered stores and any outstanding read; a later stray mem_rsp_valid is ignored in IDLE.
- Store buffer:
  - Circular FIFO of {word addr, data}.
  - STORE with count<SB_DEPTH: enqueued at the clock edge, dmem_stall=0 that cycle.
  - STORE with count==SB_DEPTH: dmem_stall=1 until a slot frees.
    - No enqueue in a cycle where the buffer is full at the start of the cycle, even if a pop occurs in that cycle.
  - Pointers wrap modulo SB_DEPTH.
  - count is a $clog2(SB_DEPTH)+1 bit field.
- Load forwarding:
  - LOAD whose word address matches any valid buffer entry: mem2proc_data = data of the youngest matching entry, combinational in the same cycle.
  - dmem_stall=0, no memory request issued.
- Load miss FSM:
  - IDLE, LOAD, no match: dmem_stall=1.
    - If no drain request is in flight, go to LD_REQ next cycle.
    - Otherwise wait in IDLE until the drain handshake completes.
  - LD_REQ: mem_req_valid=1, we=0, addr=load addr, dmem_stall=1.
    - On mem_req_ready, go to LD_RSP.
  - LD_RSP: dmem_stall=1, mem_req_valid=0.
    - On mem_rsp_valid, capture mem_rsp_data into a result register and go to LD_DONE.
  - LD_DONE: dmem_stall=0, mem2proc_data = result register; go to IDLE next cycle.
  - Miss latency is at least 3 cycles of stall (LD_REQ, LD_RSP, then LD_DONE delivers).
  - Read misses bypass buffered stores: no address overlap is guaranteed by the forwarding check.
- Drain:
  - In IDLE with count>0 and no load miss pending: present head entry (mem_req_valid=1, we=1).
  - Pop on mem_req_ready; writes have no response.
  - Once mem_req_valid rises, addr/wdata/we stay stable until ready. The request is never withdrawn, even if a LOAD arrives.
  - Priority: an in-flight drain completes first, then the load miss, then further drains.
- Simultaneous events:
  - Enqueue and pop in the same cycle: count unchanged, both pointers advance.
  - A STORE arriving during LD_REQ/LD_RSP cannot occur, since the pipeline is stalled.
- Unaligned addresses are silently word-aligned.

Test Plan:
- Reset low mid-LD_RSP, with 2 stores buffered -> all outputs 0, count=0; mem_rsp_valid pulsed after release is ignored, no stall.
- 4 STOREs to 0x10,0x14,0x18,0x1C with mem_req_ready=0 -> no stall on any; a 5th STORE to 0x20 -> dmem_stall=1 until ready=1 pops 0x10, then it enqueues; memory sees writes in order 0x10,0x14,0x18,0x1C,0x20.
- STORE 0x40=0xAAAA then STORE 0x40=0xBBBB (ready=0), then LOAD 0x42 -> same-cycle mem2proc_data=0xBBBB, dmem_stall=0, no read request.
- LOAD 0x100 miss, buffer empty, ready=1, rsp_valid 3 cycles after accept with 0xDEADBEEF -> stall for 5 cycles, then one cycle stall=0 with data 0xDEADBEEF.
- Drain of 0x10 in flight (ready=0 two cycles) when LOAD 0x200 arrives -> write request held stable until ready; read request for 0x200 issued the cycle after the write pop; remaining stores are not drained until LD_DONE.
- Enqueue and drain pop in the same cycle at count=2 -> count stays 2; tail pointer wraps from 3 to 0 correctly.
